// File: rtl/btn_cond_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
// Exposes the per-channel FSM state encoding and debounce/hold/repeat defaults.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    // 10 ms debounce at 125 MHz
    localparam int DB_CYCLES_DEF     = 1_250_000;
    // 0.5 s before auto-repeat starts, then every 0.1 s
    localparam int HOLD_CYCLES_DEF   = 62_500_000;
    localparam int REPEAT_CYCLES_DEF = 12_500_000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, counter-based debounce FSM and
// registered level / press / release outputs.
// Ports: clk, reset (async active-low), btn_raw (async pin),
//        btn_level, btn_press, btn_release (registered).
// Optional auto-repeat of btn_press when BTN_COND_REPEAT_EN is defined.
module btn_debounce_ch
    import btn_cond_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF
`ifdef BTN_COND_REPEAT_EN
    ,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic       sync1_q;
    logic       sync2_q;
    btn_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic level_q, level_d;
    logic press_q, press_d;
    logic release_q, release_d;
    logic rep_fire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RELEASED: begin
                if (sync2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = RELEASED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Outputs are a registered view of the FSM: edges of the held level
    // (PRESSED or RELEASE_WAIT) against level_q give the one-cycle pulses.
    // A RELEASE_WAIT->PRESSED bounce keeps the level high, so no pulse.
    always_comb begin
        level_d   = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
        press_d   = ((state_q == PRESSED) && !level_q) || rep_fire;
        release_d = (state_q == RELEASED) && level_q;
    end

`ifdef BTN_COND_REPEAT_EN
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    // Reloading to HOLD-REPEAT+1 makes the next fire REPEAT cycles later.
    localparam logic [HOLD_W-1:0] HOLD_RLD =
        HOLD_W'(HOLD_CYCLES - REPEAT_CYCLES + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    always_comb begin
        hold_d   = '0;
        rep_fire = 1'b0;
        if (state_q == PRESSED) begin
            if (hold_q == HOLD_MAX) begin
                rep_fire = 1'b1;
                hold_d   = HOLD_RLD;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions NUM_BTN raw push-buttons into clean level / press / release.
// Ports: clk, reset (async active-low, board POR), btn_raw[NUM_BTN],
//        btn_level, btn_press, btn_release [NUM_BTN]. Macro: BTN_COND_REPEAT_EN.
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int NUM_BTN       = 2,
    parameter int DB_CYCLES     = DB_CYCLES_DEF
`ifdef BTN_COND_REPEAT_EN
    ,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYCLES     (DB_CYCLES)
`ifdef BTN_COND_REPEAT_EN
            ,
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DB_CYCLES=4 (7-cycle latency).
// Repeat checks are compiled in when BTN_COND_REPEAT_EN is defined.
module tb_btn_conditioner;

    logic       clk;
    logic       reset;
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;

    int checks = 0;
    int errors = 0;

    btn_conditioner #(
        .NUM_BTN       (2),
        .DB_CYCLES     (4)
`ifdef BTN_COND_REPEAT_EN
        ,
        .HOLD_CYCLES   (10),
        .REPEAT_CYCLES (3)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [1:0] obs,
                         input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b0;
        btn_raw = 2'b00;
        tick(3);
        check("rst_level", btn_level, 2'b00);
        check("rst_press", btn_press, 2'b00);
        check("rst_release", btn_release, 2'b00);
        reset = 1'b1;
        tick(2);

        // clean press on ch0: pulse on the 8th tick (first sample + 7)
        btn_raw = 2'b01;
        tick(7);
        check("press_early", btn_press, 2'b00);
        tick(1);
        check("press_pulse", btn_press, 2'b01);
        check("press_level", btn_level, 2'b01);
        tick(1);
        check("press_one_cycle", btn_press, 2'b00);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("press_hold_quiet", btn_press, 2'b00);
        end
        check("press_level_held", btn_level, 2'b01);

        // short release bounce from PRESSED
        btn_raw = 2'b00;
        tick(2);
        btn_raw = 2'b01;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("rel_bounce_norel", btn_release, 2'b00);
            check("rel_bounce_nopress", btn_press, 2'b00);
        end
        check("rel_bounce_level", btn_level, 2'b01);

        // clean release
        btn_raw = 2'b00;
        tick(7);
        check("release_early", btn_release, 2'b00);
        tick(1);
        check("release_pulse", btn_release, 2'b01);
        check("release_level", btn_level, 2'b00);
        tick(1);
        check("release_one_cycle", btn_release, 2'b00);
        tick(4);

        // press bounce 1,0,1,1,0 then 0
        btn_raw = 2'b01; tick(1);
        btn_raw = 2'b00; tick(1);
        btn_raw = 2'b01; tick(1);
        btn_raw = 2'b01; tick(1);
        btn_raw = 2'b00; tick(1);
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("bounce_nopress", btn_press, 2'b00);
            check("bounce_level", btn_level, 2'b00);
        end

        // simultaneous press on both channels
        btn_raw = 2'b11;
        tick(7);
        check("sim_early", btn_press, 2'b00);
        tick(1);
        check("sim_press", btn_press, 2'b11);
        tick(1);
        check("sim_level", btn_level, 2'b11);
        check("sim_one_cycle", btn_press, 2'b00);
        btn_raw = 2'b00;
        tick(7);
        tick(1);
        check("sim_release", btn_release, 2'b11);
        tick(4);
        check("sim_level_low", btn_level, 2'b00);

        // ch1 held pressed, ch0 in PRESS_WAIT, async reset mid-cycle
        btn_raw = 2'b10;
        tick(9);
        check("pre_rst_level", btn_level, 2'b10);
        btn_raw = 2'b11;
        tick(4);
        #3;
        reset = 1'b0;
        #1;
        check("async_level", btn_level, 2'b00);
        check("async_press", btn_press, 2'b00);
        check("async_release", btn_release, 2'b00);
        tick(2);
        check("in_rst_press", btn_press, 2'b00);
        check("in_rst_level", btn_level, 2'b00);
        reset = 1'b1;
        tick(7);
        check("post_rst_early", btn_press, 2'b00);
        tick(1);
        check("post_rst_press", btn_press, 2'b11);
        check("post_rst_level", btn_level, 2'b11);
        btn_raw = 2'b00;
        tick(12);
        check("post_rst_released", btn_level, 2'b00);

`ifdef BTN_COND_REPEAT_EN
        // hold ch0: pulses at +0, +10, +13, +16, +19, +22
        btn_raw = 2'b01;
        tick(8);
        check("rep_first", btn_press, 2'b01);
        for (int t = 1; t <= 25; t++) begin
            tick(1);
            if (t == 10 || t == 13 || t == 16 || t == 19 || t == 22)
                check("rep_pulse", btn_press, 2'b01);
            else
                check("rep_gap", btn_press, 2'b00);
        end
        btn_raw = 2'b00;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            check("rep_stop", btn_press, 2'b00);
        end
        check("rep_released", btn_level, 2'b00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
